arb_mux: RTL and testbench

- Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes and one registered output stage.
- Generalises the fixed 4:1 select mux. The select is produced internally by a fixed-priority or round-robin arbiter instead of an external sel.
- Sits between multiple requesters (fetch, load/store, debug) and a single shared consumer, e.g. a memory port.

---
 rtl/arb_mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/arb_mux.sv | 81 ++++++++
 tb/tb_arb_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// ----------------------------------------------------------------
// arb_mux_pkg : shared constants and helpers for the arbitrated mux
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A single channel still needs a 1-bit index port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------
// rr_arbiter : fixed-priority / round-robin grant with pointer register
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  req,
  input  logic            advance,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] w_base;
  logic [SELW:0]   w_cand;
  logic [SELW:0]   w_next;
  logic            w_found;

  // Fixed-priority mode is round-robin with the search base pinned at 0.
  assign w_base = (MODE == ARB_RR) ? r_ptr : '0;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = {1'b0, w_base} + (SELW+1)'(k);
      if (w_cand >= (SELW+1)'(NCH))
        w_cand = w_cand - (SELW+1)'(NCH);
      if (!w_found && req[w_cand[SELW-1:0]]) begin
        w_found   = 1'b1;
        grant_idx = w_cand[SELW-1:0];
      end
    end
    if (w_found)
      grant[grant_idx] = 1'b1;
  end

  assign w_next = {1'b0, grant_idx} + (SELW+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (advance && (MODE == ARB_RR))
      r_ptr <= (w_next >= (SELW+1)'(NCH)) ? '0 : w_next[SELW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
// ----------------------------------------------------------------
// arb_mux : N-channel valid/ready arbitrated mux, one output register
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int W    = 32,
  parameter int NCH  = 4,
  parameter int MODE = ARB_RR,
  localparam int SELW = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_sel,
  input  logic             out_ready
);

  logic [NCH-1:0]  w_grant;
  logic [SELW-1:0] w_grant_idx;
  logic            w_load;
  logic            w_xfer;
  logic [W-1:0]    w_data;

  logic            r_valid;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_sel;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_load = !r_valid || out_ready;

  // Reset suppresses in_ready so no requester sees a phantom accept.
  assign in_ready = (rst_n && w_load) ? w_grant : '0;
  assign w_xfer   = |in_ready;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NCH; i++)
      if (w_grant[i])
        w_data = w_data | in_data[i*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_sel   <= w_grant_idx;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
// ----------------------------------------------------------------
// tb_arb_mux : directed self-checking bench for arb_mux (RR, fixed, NCH=3)
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_arb_mux;

  logic clk;
  logic rst_n;

  logic [3:0]  rr_valid, rr_irdy;
  logic [31:0] rr_data;
  logic        rr_ordy, rr_ovalid;
  logic [7:0]  rr_odata;
  logic [1:0]  rr_osel;

  logic [3:0]  fx_valid, fx_irdy;
  logic [31:0] fx_data;
  logic        fx_ordy, fx_ovalid;
  logic [7:0]  fx_odata;
  logic [1:0]  fx_osel;

  logic [2:0]  n3_valid, n3_irdy;
  logic [23:0] n3_data;
  logic        n3_ordy, n3_ovalid;
  logic [7:0]  n3_odata;
  logic [1:0]  n3_osel;

  int n_checks = 0;
  int n_pass   = 0;

  arb_mux #(.W(8), .NCH(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_irdy),
    .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel), .out_ready(rr_ordy));

  arb_mux #(.W(8), .NCH(4), .MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(fx_valid), .in_data(fx_data), .in_ready(fx_irdy),
    .out_valid(fx_ovalid), .out_data(fx_odata), .out_sel(fx_osel), .out_ready(fx_ordy));

  arb_mux #(.W(8), .NCH(3), .MODE(1)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(n3_valid), .in_data(n3_data), .in_ready(n3_irdy),
    .out_valid(n3_ovalid), .out_data(n3_odata), .out_sel(n3_osel), .out_ready(n3_ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    rr_valid = 4'b1111; rr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; rr_ordy = 1'b1;
    fx_valid = '0; fx_data = '0; fx_ordy = 1'b1;
    n3_valid = '0; n3_data = '0; n3_ordy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (rr_ovalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rr_ovalid); else n_pass++;
      n_checks++; if (rr_odata !== 8'h00) $display("FAIL reset_data: got %h want 00", rr_odata); else n_pass++;
      n_checks++; if (rr_osel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", rr_osel); else n_pass++;
      n_checks++; if (rr_irdy !== 4'b0000) $display("FAIL reset_in_ready: got %b want 0000", rr_irdy); else n_pass++;
    end
    rst_n = 1'b1;
    #1;
    n_checks++; if (rr_irdy !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", rr_irdy); else n_pass++;
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_d;
    logic [3:0] exp_r;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_d = 8'hA0 + 8'(k % 4);
      exp_r = 4'(1 << ((k + 1) % 4));
      n_checks++; if (rr_ovalid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", k, rr_ovalid); else n_pass++;
      n_checks++; if (rr_osel !== 2'(k % 4)) $display("FAIL rr_sel[%0d]: got %0d want %0d", k, rr_osel, k % 4); else n_pass++;
      n_checks++; if (rr_odata !== exp_d) $display("FAIL rr_data[%0d]: got %h want %h", k, rr_odata, exp_d); else n_pass++;
      n_checks++; if (rr_irdy !== exp_r) $display("FAIL rr_in_ready[%0d]: got %b want %b", k, rr_irdy, exp_r); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    rr_valid = 4'b0100; rr_data = {8'hA3, 8'h55, 8'hA1, 8'hA0}; rr_ordy = 1'b1;
    #1;
    n_checks++; if (rr_irdy !== 4'b0100) $display("FAIL bp_accept: got %b want 0100", rr_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rr_odata !== 8'h55) $display("FAIL bp_load_data: got %h want 55", rr_odata); else n_pass++;
    n_checks++; if (rr_osel !== 2'd2) $display("FAIL bp_load_sel: got %0d want 2", rr_osel); else n_pass++;
    rr_ordy = 1'b0; rr_data = {8'hA3, 8'h66, 8'hA1, 8'hA0};
    #1;
    n_checks++; if (rr_irdy !== 4'b0000) $display("FAIL bp_stall_ready0: got %b want 0000", rr_irdy); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (rr_ovalid !== 1'b1) $display("FAIL bp_stall_valid[%0d]: got %b want 1", c, rr_ovalid); else n_pass++;
      n_checks++; if (rr_odata !== 8'h55) $display("FAIL bp_stall_data[%0d]: got %h want 55", c, rr_odata); else n_pass++;
      n_checks++; if (rr_irdy !== 4'b0000) $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, rr_irdy); else n_pass++;
    end
    rr_ordy = 1'b1;
    #1;
    n_checks++; if (rr_irdy !== 4'b0100) $display("FAIL bp_release_ready: got %b want 0100", rr_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rr_ovalid !== 1'b1) $display("FAIL bp_reload_valid: got %b want 1", rr_ovalid); else n_pass++;
    n_checks++; if (rr_odata !== 8'h66) $display("FAIL bp_reload_data: got %h want 66", rr_odata); else n_pass++;
    rr_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (rr_ovalid !== 1'b0) $display("FAIL drain_valid: got %b want 0", rr_ovalid); else n_pass++;
    n_checks++; if (rr_odata !== 8'h66) $display("FAIL drain_data_hold: got %h want 66", rr_odata); else n_pass++;
    n_checks++; if (rr_osel !== 2'd2) $display("FAIL drain_sel_hold: got %0d want 2", rr_osel); else n_pass++;
  endtask

  task automatic test_fixed();
    fx_valid = 4'b1010; fx_data = {8'h33, 8'h00, 8'h11, 8'h00}; fx_ordy = 1'b1;
    #1;
    n_checks++; if (fx_irdy !== 4'b0010) $display("FAIL fx_ready0: got %b want 0010", fx_irdy); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (fx_osel !== 2'd1) $display("FAIL fx_sel[%0d]: got %0d want 1", c, fx_osel); else n_pass++;
      n_checks++; if (fx_odata !== 8'h11) $display("FAIL fx_data[%0d]: got %h want 11", c, fx_odata); else n_pass++;
      n_checks++; if (fx_irdy !== 4'b0010) $display("FAIL fx_ready[%0d]: got %b want 0010", c, fx_irdy); else n_pass++;
    end
    fx_valid = 4'b1000;
    #1;
    n_checks++; if (fx_irdy !== 4'b1000) $display("FAIL fx_ready_ch3: got %b want 1000", fx_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (fx_osel !== 2'd3) $display("FAIL fx_sel_ch3: got %0d want 3", fx_osel); else n_pass++;
    n_checks++; if (fx_odata !== 8'h33) $display("FAIL fx_data_ch3: got %h want 33", fx_odata); else n_pass++;
    fx_valid = 4'b0000;
  endtask

  task automatic test_wrap_nch3();
    n3_valid = 3'b010; n3_data = {8'h22, 8'h21, 8'h20}; n3_ordy = 1'b1;
    #1;
    n_checks++; if (n3_irdy !== 3'b010) $display("FAIL n3_ready_ch1: got %b want 010", n3_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (n3_osel !== 2'd1) $display("FAIL n3_sel_ch1: got %0d want 1", n3_osel); else n_pass++;
    n_checks++; if (n3_odata !== 8'h21) $display("FAIL n3_data_ch1: got %h want 21", n3_odata); else n_pass++;
    n3_valid = 3'b111;
    #1;
    n_checks++; if (n3_irdy !== 3'b100) $display("FAIL n3_ptr2: got %b want 100", n3_irdy); else n_pass++;
    n3_valid = 3'b001;
    #1;
    n_checks++; if (n3_irdy !== 3'b001) $display("FAIL n3_wrap_ready: got %b want 001", n3_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (n3_osel !== 2'd0) $display("FAIL n3_wrap_sel: got %0d want 0", n3_osel); else n_pass++;
    n_checks++; if (n3_odata !== 8'h20) $display("FAIL n3_wrap_data: got %h want 20", n3_odata); else n_pass++;
    n3_valid = 3'b111;
    #1;
    n_checks++; if (n3_irdy !== 3'b010) $display("FAIL n3_ptr1: got %b want 010", n3_irdy); else n_pass++;
    n3_valid = 3'b000;
    @(negedge clk);
    n_checks++; if (n3_ovalid !== 1'b0) $display("FAIL n3_drain: got %b want 0", n3_ovalid); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    rr_valid = 4'b0010; rr_data = {8'hA3, 8'hA2, 8'h77, 8'hA0}; rr_ordy = 1'b1;
    @(negedge clk);
    n_checks++; if (rr_odata !== 8'h77) $display("FAIL ms_load_data: got %h want 77", rr_odata); else n_pass++;
    rr_ordy = 1'b0; rr_valid = 4'b1111; rr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    n_checks++; if (rr_odata !== 8'h77 || rr_ovalid !== 1'b1) $display("FAIL ms_hold: got %b/%h want 1/77", rr_ovalid, rr_odata); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rr_irdy !== 4'b0000) $display("FAIL ms_rst_ready: got %b want 0000", rr_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rr_ovalid !== 1'b0) $display("FAIL ms_rst_valid: got %b want 0", rr_ovalid); else n_pass++;
    n_checks++; if (rr_odata !== 8'h00) $display("FAIL ms_rst_data: got %h want 00", rr_odata); else n_pass++;
    n_checks++; if (rr_osel !== 2'd0) $display("FAIL ms_rst_sel: got %0d want 0", rr_osel); else n_pass++;
    n_checks++; if (rr_irdy !== 4'b0000) $display("FAIL ms_rst_ready2: got %b want 0000", rr_irdy); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (rr_irdy !== 4'b0001) $display("FAIL ms_ptr0: got %b want 0001", rr_irdy); else n_pass++;
    @(negedge clk);
    n_checks++; if (rr_osel !== 2'd0 || rr_odata !== 8'hA0) $display("FAIL ms_after: got %0d/%h want 0/a0", rr_osel, rr_odata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_fixed();
    test_wrap_nch3();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
